// File: rtl/wallace_final_adder.sv
// Sequential carry-propagate adder closing the Wallace-tree multiplier.
// Resolves CSA sum/carry vectors CHUNK bits per cycle over valid/ready.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (sum_vec, carry_vec)
//   sum_vec, carry_vec   WIDTH-bit CSA vectors
//   out_valid/out_ready  result handshake
//   result               (sum_vec + carry_vec) mod 2^WIDTH
//   carry_out            bit WIDTH of the full sum
module wallace_final_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_vec,
  input  logic [WIDTH-1:0] carry_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_s_q, op_s_d;
  logic [WIDTH-1:0] op_c_q, op_c_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;
  logic [CHUNK:0]   csum;
  logic             last;

  // One chunk of the ripple: operands at slot cnt_q plus carry-in.
  assign csum = {1'b0, op_s_q[cnt_q*CHUNK +: CHUNK]}
              + {1'b0, op_c_q[cnt_q*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, cy_q};

  assign last = (cnt_q == CW'(NCHUNK - 1));

  // in_ready is masked by rst so the block never advertises
  // readiness while held in reset.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign carry_out = cout_q;

  always_comb begin
    state_d = state_q;
    op_s_d  = op_s_q;
    op_c_d  = op_c_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_s_d  = sum_vec;
          op_c_d  = carry_vec;
          cnt_d   = '0;
          cy_d    = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        res_d[cnt_q*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        cy_d  = csum[CHUNK];
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          cout_d  = csum[CHUNK];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_s_q  <= '0;
      op_c_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_s_q  <= op_s_d;
      op_c_q  <= op_c_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_wallace_final_adder.sv
// Bench for wallace_final_adder: scoreboard of expected sums,
// popped on each output handshake.
module tb_wallace_final_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] sum_vec;
  logic [63:0] carry_vec;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        carry_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = -1;
  int hs_cyc = -1;
  logic [64:0] sb_q[$];

  wallace_final_adder #(.WIDTH(64), .CHUNK(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_vec   (sum_vec),
    .carry_vec (carry_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [64:0] got,
                     input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        hs_cyc = cyc;
        if (sb_q.size() == 0) begin
          chk("spurious_out", 65'd1, 65'd0);
        end else begin
          logic [64:0] e;
          e = sb_q.pop_front();
          chk("result", {1'b0, result}, {1'b0, e[63:0]});
          chk("carry_out", {64'd0, carry_out}, {64'd0, e[64]});
        end
      end
      if (in_valid && in_ready) begin
        acc_cyc = cyc;
        sb_q.push_back({1'b0, sum_vec} + {1'b0, carry_vec});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and return #1 after the accepting edge.
  // in_valid is left high; callers drop it.
  task automatic send(input logic [63:0] s, input logic [63:0] c);
    logic acc;
    acc = 1'b0;
    in_valid  = 1'b1;
    sum_vec   = s;
    carry_vec = c;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 65'd0, 65'd1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) break;
      tick();
      n++;
    end
    if (!out_valid) chk("out_timeout", 65'd0, 65'd1);
  endtask

  initial begin
    int lat;
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sum_vec   = '0;
    carry_vec = '0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", {64'd0, in_ready}, 65'd0);
    chk("rst_out_valid", {64'd0, out_valid}, 65'd0);
    chk("rst_result", {1'b0, result}, 65'd0);
    chk("rst_carry_out", {64'd0, carry_out}, 65'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {64'd0, in_ready}, 65'd1);

    // Basic
    send(64'h0000_0000_0000_00FF, 64'h1);
    in_valid = 1'b0;
    wait_out(lat);
    chk("basic_latency", 65'(lat), 65'd4);
    chk("basic_val", {1'b0, result}, 65'h100);
    tick();

    // Full carry chain across every chunk boundary
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    in_valid = 1'b0;
    wait_out(lat);
    chk("chain_latency", 65'(lat), 65'd4);
    chk("chain_val", {carry_out, result}, {1'b1, 64'h0});
    tick();

    // Backpressure; a new operand pulse must be ignored
    out_ready = 1'b0;
    send(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001);
    in_valid = 1'b0;
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid  = (i == 1);
      sum_vec   = 64'h1234;
      carry_vec = 64'h4321;
      chk("bp_out_valid", {64'd0, out_valid}, 65'd1);
      chk("bp_in_ready", {64'd0, in_ready}, 65'd0);
      chk("bp_hold", {carry_out, result},
          {1'b0, 64'h0001_0000_0001_0000});
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_in_ready_after", {64'd0, in_ready}, 65'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("bp_second_not_latched", {64'd0, seen}, 65'd0);

    // Reset mid-ADD at counter=2, held two cycles
    send(64'h1234_5678, 64'h5);
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_in_ready", {64'd0, in_ready}, 65'd0);
    chk("midrst_out_valid", {64'd0, out_valid}, 65'd0);
    chk("midrst_result", {1'b0, result}, 65'd0);
    tick();
    chk("midrst_carry_out", {64'd0, carry_out}, 65'd0);
    chk("midrst_in_ready2", {64'd0, in_ready}, 65'd0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_rel", {64'd0, in_ready}, 65'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("midrst_no_out", {64'd0, seen}, 65'd0);

    // Back-to-back with in_valid held continuously
    send(64'h5, 64'h4);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    in_valid = 1'b0;
    chk("b2b_accept_gap", 65'(acc_cyc - hs_cyc), 65'd1);
    wait_out(lat);
    tick();
    tick();

    chk("sb_empty", 65'(sb_q.size()), 65'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
